// File: rtl/tile_csr_pkg.sv
// Shared CSR layout, opcode and FSM types
// for the iterative multiply/divide tile.
package tile_csr_pkg;

    localparam int START_BIT  = 15;
    localparam int ABORT_BIT  = 14;
    localparam int OP_LSB     = 0;
    localparam int OP_MSB     = 3;

    localparam int ST_DONE    = 0;
    localparam int ST_DIV0    = 1;
    localparam int ST_ILLEGAL = 2;
    localparam int ST_ABORTED = 3;
    localparam int ST_BUSY    = 4;
    localparam int ST_OP_LSB  = 5;
    localparam int ST_CNT_LSB = 8;

    localparam logic [3:0] F_NONE    = 4'b0000;
    localparam logic [3:0] F_DONE    = 4'b0001;
    localparam logic [3:0] F_DIV0    = 4'b0010;
    localparam logic [3:0] F_ILLEGAL = 4'b0100;
    localparam logic [3:0] F_ABORTED = 4'b1000;

    typedef enum logic [3:0] {
        OP_DIVU = 4'd0,
        OP_REMU = 4'd1,
        OP_MULL = 4'd2,
        OP_MULH = 4'd3
    } op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Status word: {counter, op[2:0], busy, event flags}
    function automatic logic [15:0] pack_status(
        input logic [7:0] cnt,
        input logic [2:0] op,
        input logic       busy,
        input logic [3:0] flags
    );
        return {cnt, op, busy, flags};
    endfunction

endpackage

// File: rtl/muldiv_iter_dp.sv
// Operand/partial registers and one
// restoring-divide or shift-add step.
module muldiv_iter_dp
    import tile_csr_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         i_load,
    input  logic         i_step,
    input  logic         i_mul,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_acc,
    output logic [W-1:0] o_sh
);

    // acc: remainder or product high word
    // sh : quotient or product low word
    logic [W-1:0] r_acc;
    logic [W-1:0] r_sh;
    logic [W-1:0] r_opnd;
    logic         r_mul;

    logic [W:0]   w_trial;
    logic [W:0]   w_sum;

    assign w_trial = {r_acc, r_sh[W-1]} - {1'b0, r_opnd};
    assign w_sum   = {1'b0, r_acc}
                   + (r_sh[0] ? {1'b0, r_opnd} : '0);

    // Load operands, then one iteration per step
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_acc  <= '0;
            r_sh   <= '0;
            r_opnd <= '0;
            r_mul  <= 1'b0;
        end else if (i_load) begin
            r_acc  <= '0;
            r_sh   <= i_mul ? i_b : i_a;
            r_opnd <= i_mul ? i_a : i_b;
            r_mul  <= i_mul;
        end else if (i_step) begin
            if (r_mul) begin
                r_acc <= w_sum[W:1];
                r_sh  <= {w_sum[0], r_sh[W-1:1]};
            end else if (!w_trial[W]) begin
                r_acc <= w_trial[W-1:0];
                r_sh  <= {r_sh[W-2:0], 1'b1};
            end else begin
                r_acc <= {r_acc[W-2:0], r_sh[W-1]};
                r_sh  <= {r_sh[W-2:0], 1'b0};
            end
        end
    end

    assign o_acc = r_acc;
    assign o_sh  = r_sh;

endmodule

// File: rtl/iter_muldiv_tile.sv
// CSR-driven iterative multiply/divide tile:
// command FSM, counters and status strobes.
module iter_muldiv_tile
    import tile_csr_pkg::*;
#(
    parameter int REG_WIDTH     = 32,
    parameter int CSR_IN_WIDTH  = 16,
    parameter int CSR_OUT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic [CSR_IN_WIDTH-1:0]  csr_in,
    input  logic [REG_WIDTH-1:0]     data_reg_a,
    input  logic [REG_WIDTH-1:0]     data_reg_b,
    output logic                     csr_in_re,
    output logic [CSR_OUT_WIDTH-1:0] csr_out,
    output logic                     csr_out_we,
    output logic [REG_WIDTH-1:0]     data_reg_c
);

    localparam int CW = $clog2(REG_WIDTH);

    state_e                   r_state;
    logic [CW-1:0]            r_cnt;
    logic [7:0]               r_done_cnt;
    logic [3:0]               r_op;
    logic                     r_ill;
    logic                     r_div0;
    logic                     r_re;
    logic                     r_we;
    logic [CSR_OUT_WIDTH-1:0] r_csr_out;
    logic [REG_WIDTH-1:0]     r_c;

    logic                     w_start;
    logic                     w_abort;
    logic [3:0]               w_op;
    logic                     w_op_ill;
    logic                     w_op_div0;
    logic                     w_load;
    logic                     w_step;
    logic [REG_WIDTH-1:0]     w_acc;
    logic [REG_WIDTH-1:0]     w_sh;
    logic [7:0]               w_cnt_nx;
    logic                     w_unused;

    assign w_start   = csr_in[START_BIT];
    assign w_abort   = csr_in[ABORT_BIT];
    assign w_op      = csr_in[OP_MSB:OP_LSB];
    assign w_op_ill  = (w_op > OP_MULH);
    assign w_op_div0 = (w_op <= OP_REMU)
                     && (data_reg_b == '0);
    assign w_load    = (r_state == IDLE) && w_start;
    assign w_step    = (r_state == RUN) && !w_abort;
    assign w_cnt_nx  = r_done_cnt + 8'd1;
    assign w_unused  = ^csr_in[ABORT_BIT-1:OP_MSB+1];

    muldiv_iter_dp #(.W(REG_WIDTH)) u_dp (
        .clk    (clk),
        .arst_n (arst_n),
        .i_load (w_load),
        .i_step (w_step),
        .i_mul  (w_op[1]),
        .i_a    (data_reg_a),
        .i_b    (data_reg_b),
        .o_acc  (w_acc),
        .o_sh   (w_sh)
    );

    // Command FSM with registered strobes/result
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_done_cnt <= '0;
            r_op       <= '0;
            r_ill      <= 1'b0;
            r_div0     <= 1'b0;
            r_re       <= 1'b0;
            r_we       <= 1'b0;
            r_csr_out  <= '0;
            r_c        <= '0;
        end else begin
            r_re <= 1'b0;
            r_we <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_op      <= w_op;
                        r_ill     <= w_op_ill;
                        r_div0    <= w_op_div0;
                        r_cnt     <= '0;
                        r_re      <= 1'b1;
                        r_we      <= 1'b1;
                        r_csr_out <= CSR_OUT_WIDTH'(pack_status(
                            r_done_cnt, w_op[2:0], 1'b1, F_NONE));
                        r_state   <= (w_op_ill || w_op_div0)
                                   ? FINISH : RUN;
                    end
                end
                RUN: begin
                    if (w_abort) begin
                        r_we      <= 1'b1;
                        r_csr_out <= CSR_OUT_WIDTH'(pack_status(
                            r_done_cnt, r_op[2:0], 1'b0, F_ABORTED));
                        r_state   <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == CW'(REG_WIDTH - 1)) begin
                            r_state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    r_we       <= 1'b1;
                    r_done_cnt <= w_cnt_nx;
                    r_state    <= IDLE;
                    if (r_ill) begin
                        r_csr_out <= CSR_OUT_WIDTH'(pack_status(
                            w_cnt_nx, r_op[2:0], 1'b0, F_ILLEGAL));
                    end else if (r_div0) begin
                        r_csr_out <= CSR_OUT_WIDTH'(pack_status(
                            w_cnt_nx, r_op[2:0], 1'b0, F_DIV0));
                        r_c <= (r_op == OP_REMU) ? w_sh : '1;
                    end else begin
                        r_csr_out <= CSR_OUT_WIDTH'(pack_status(
                            w_cnt_nx, r_op[2:0], 1'b0, F_DONE));
                        unique case (r_op[1:0])
                            2'd0: r_c <= w_sh;
                            2'd1: r_c <= w_acc;
                            2'd2: r_c <= w_sh;
                            2'd3: r_c <= w_acc;
                        endcase
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign csr_in_re  = r_re;
    assign csr_out_we = r_we;
    assign csr_out    = r_csr_out;
    assign data_reg_c = r_c;

endmodule

// File: tb/tb_iter_muldiv_tile.sv
// Self-checking bench for iter_muldiv_tile:
// directed cases plus randomized ops vs. model.
module tb_iter_muldiv_tile;

    logic        clk;
    logic        arst_n;
    logic [15:0] csr_in;
    logic [31:0] data_reg_a;
    logic [31:0] data_reg_b;
    logic        csr_in_re;
    logic [15:0] csr_out;
    logic        csr_out_we;
    logic [31:0] data_reg_c;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_cnt = 0;
    logic [31:0] exp_c   = 0;

    iter_muldiv_tile dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .csr_in     (csr_in),
        .data_reg_a (data_reg_a),
        .data_reg_b (data_reg_b),
        .csr_in_re  (csr_in_re),
        .csr_out    (csr_out),
        .csr_out_we (csr_out_we),
        .data_reg_c (data_reg_c)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h",
                   tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] status(
        input logic [7:0] cnt, input logic [3:0] op,
        input logic busy, input logic [3:0] fl);
        return {cnt, op[2:0], busy, fl};
    endfunction

    // One complete command; model computed with
    // plain arithmetic from the op definitions.
    task automatic do_op(input logic [31:0] a,
                         input logic [31:0] b,
                         input logic [3:0]  op,
                         input bit          with_abort);
        logic [63:0] prod;
        logic [3:0]  fl;
        int          exp_lat;
        int          lat;
        bit          seen;
        bit          extra;
        prod = 64'(a) * 64'(b);
        exp_lat = 34;
        if (op > 3) begin
            fl = 4'b0100;
            exp_lat = 2;
        end else if (op <= 1 && b == 0) begin
            fl = 4'b0010;
            exp_lat = 2;
            exp_c = (op == 0) ? 32'hFFFF_FFFF : a;
        end else begin
            fl = 4'b0001;
            case (op)
                4'd0: exp_c = a / b;
                4'd1: exp_c = a % b;
                4'd2: exp_c = prod[31:0];
                default: exp_c = prod[63:32];
            endcase
        end
        @(negedge clk);
        chk("idle_we", 64'(csr_out_we), 64'd0);
        data_reg_a = a;
        data_reg_b = b;
        csr_in = {1'b1, with_abort, 10'd0, op};
        @(negedge clk);
        csr_in = 16'd0;
        chk("start_re", 64'(csr_in_re), 64'd1);
        chk("start_we", 64'(csr_out_we), 64'd1);
        chk("busy_word", 64'(csr_out),
            64'(status(exp_cnt, op, 1'b1, 4'd0)));
        lat = 1;
        seen = 0;
        extra = 0;
        while (lat < 100 && !seen) begin
            @(negedge clk);
            lat++;
            if (csr_in_re) extra = 1;
            if (csr_out_we) seen = 1;
        end
        exp_cnt = exp_cnt + 8'd1;
        chk("finish_seen", 64'(seen), 64'd1);
        chk("latency", 64'(lat), 64'(exp_lat));
        chk("extra_re", 64'(extra), 64'd0);
        chk("finish_word", 64'(csr_out),
            64'(status(exp_cnt, op, 1'b0, fl)));
        chk("result_c", 64'(data_reg_c), 64'(exp_c));
    endtask

    initial begin
        bit re_any;
        bit we_any;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [3:0]  rop;
        csr_in = 0;
        data_reg_a = 0;
        data_reg_b = 0;
        arst_n = 0;
        #1;
        chk("rst_re", 64'(csr_in_re), 64'd0);
        chk("rst_we", 64'(csr_out_we), 64'd0);
        chk("rst_csr", 64'(csr_out), 64'd0);
        chk("rst_c", 64'(data_reg_c), 64'd0);
        repeat (2) @(negedge clk);
        arst_n = 1;

        do_op(32'd100, 32'd7, 4'd0, 0);
        do_op(32'd100, 32'd7, 4'd1, 0);
        do_op(32'hFFFF_FFFF, 32'd2, 4'd3, 0);
        do_op(32'hFFFF_FFFF, 32'd2, 4'd2, 0);
        do_op(32'd5, 32'd0, 4'd0, 0);
        do_op(32'd5, 32'd0, 4'd1, 0);
        do_op(32'd5, 32'd3, 4'd9, 0);
        do_op(32'd12345, 32'd0, 4'd2, 0);
        do_op(32'd1000, 32'd9, 4'd0, 1);

        // ABORT in IDLE is ignored
        @(negedge clk);
        csr_in = 16'h4000;
        @(negedge clk);
        csr_in = 0;
        chk("idle_abort_we", 64'(csr_out_we), 64'd0);
        chk("idle_abort_re", 64'(csr_in_re), 64'd0);

        // ABORT mid-RUN with a stray START
        @(negedge clk);
        data_reg_a = 32'd777;
        data_reg_b = 32'd5;
        csr_in = 16'h8000;
        @(negedge clk);
        csr_in = 0;
        chk("ab_start_re", 64'(csr_in_re), 64'd1);
        re_any = 0;
        we_any = 0;
        for (int i = 0; i < 9; i++) begin
            csr_in = (i == 3) ? 16'h8002 : 16'h0000;
            @(negedge clk);
            if (csr_in_re) re_any = 1;
            if (csr_out_we) we_any = 1;
        end
        chk("run_start_re", 64'(re_any), 64'd0);
        chk("run_we", 64'(we_any), 64'd0);
        csr_in = 16'h4000;
        @(negedge clk);
        csr_in = 0;
        chk("abort_we", 64'(csr_out_we), 64'd1);
        chk("abort_word", 64'(csr_out),
            64'(status(exp_cnt, 4'd0, 1'b0, 4'b1000)));
        chk("abort_c", 64'(data_reg_c), 64'(exp_c));
        @(negedge clk);
        chk("abort_we_1cyc", 64'(csr_out_we), 64'd0);

        do_op(32'd81, 32'd9, 4'd0, 0);

        // Randomized back-to-back ops (counter wraps)
        for (int n = 0; n < 260; n++) begin
            ra  = $urandom;
            rb  = ($urandom_range(0, 9) == 0) ? 32'd0
                : ($urandom_range(0, 1) != 0) ? $urandom
                : 32'($urandom_range(1, 300));
            rop = ($urandom_range(0, 11) == 0)
                ? 4'($urandom_range(4, 15))
                : 4'($urandom_range(0, 3));
            do_op(ra, rb, rop, 0);
        end

        // Reset mid-RUN
        @(negedge clk);
        data_reg_a = 32'd50;
        data_reg_b = 32'd3;
        csr_in = 16'h8000;
        @(negedge clk);
        csr_in = 0;
        repeat (5) @(negedge clk);
        arst_n = 0;
        #1;
        chk("mid_rst_re", 64'(csr_in_re), 64'd0);
        chk("mid_rst_we", 64'(csr_out_we), 64'd0);
        chk("mid_rst_csr", 64'(csr_out), 64'd0);
        chk("mid_rst_c", 64'(data_reg_c), 64'd0);
        @(negedge clk);
        arst_n = 1;
        exp_cnt = 0;
        exp_c = 0;
        do_op(32'd9, 32'd4, 4'd3, 0);
        do_op(32'd9, 32'd4, 4'd1, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
